// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer arbiter.
package buzzer_pkg;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 22;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Next requester index in round-robin order, wrapping 2 -> 0.
  function automatic logic [IDX_W-1:0] rr_step(input logic [IDX_W-1:0] idx);
    return (idx >= IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin selector: first set mask bit after last_grant.
module rr_pick3
  import buzzer_pkg::*;
(
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at last_grant+1; the first hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = last_grant;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_step(cand);
      if (!valid && mask[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Arbitrates beep requests from three sources onto a single horn, one beep
// plus a silent gap per grant, served round-robin.
module buzzer_arbiter
  import buzzer_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 2_500_000,
  parameter int unsigned GAP_CYCLES  = 1_250_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic             playNext,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [NREQ-1:0]  pending, pending_nx;
  logic [IDX_W-1:0] last_grant, last_nx;
  logic [IDX_W-1:0] grant_nx;
  logic             play_nx, busy_nx, done_nx;
  logic             grant_go;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_index;
  logic [NREQ-1:0]  req_all;

  // Fresh pulses count immediately so a request is served the cycle after it lands.
  assign req_all = req | pending;

  rr_pick3 u_pick (
    .mask       (req_all),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  // State, counter, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      grant_id   <= '0;
      playNext   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pending    <= pending_nx;
      last_grant <= last_nx;
      grant_id   <= grant_nx;
      playNext   <= play_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Next-state and counter: counter restarts at zero on every state entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
    grant_go = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (pick_valid) begin
          state_nx = ST_BEEP;
          grant_go = 1'b1;
        end
      end
      ST_BEEP: begin
        if (cnt == BEEP_LAST) begin
          state_nx = ST_GAP;
          cnt_nx   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (pick_valid) begin
            state_nx = ST_BEEP;
            grant_go = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Output and bookkeeping next values, registered alongside the state.
  always_comb begin
    pending_nx = pending | req;
    last_nx    = last_grant;
    grant_nx   = grant_id;
    if (grant_go) begin
      pending_nx[pick_index] = 1'b0;
      last_nx                = pick_index;
      grant_nx               = pick_index;
    end
    play_nx = (state_nx == ST_BEEP);
    busy_nx = (state_nx != ST_IDLE);
    done_nx = (state == ST_BEEP) && (state_nx == ST_GAP);
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter with short beep/gap lengths.
module tb_buzzer_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       playNext;
  logic [1:0] grant_id;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  buzzer_arbiter #(
    .BEEP_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .playNext (playNext),
    .grant_id (grant_id),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: reset/req applied on the first of 'reps' cycles (zero afterwards);
  // expected outputs hold for every one of those cycles.
  typedef struct {
    logic       rst;
    logic [2:0] req;
    int         reps;
    logic       play;
    logic [1:0] gid;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    int         row;
    int         cyc;
    logic [4:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   cyc_no;

  function automatic void add(input logic r, input logic [2:0] q, input int n,
                              input logic p, input logic [1:0] g,
                              input logic b, input logic d);
    vec_t v;
    v.rst = r; v.req = q; v.reps = n; v.play = p; v.gid = g; v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  // Monitor: compare DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      logic [4:0] got;
      e   = sb_q.pop_front();
      got = {playNext, grant_id, busy, done};
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("FAIL vec row=%0d cyc=%0d got play/gid/busy/done=%b/%0d/%b/%b required %b/%0d/%b/%b",
                 e.row, e.cyc, got[4], got[3:2], got[1], got[0],
                 e.exp[4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  initial begin
    int   len;
    int   gap;
    logic saw_done;
    logic gap_end;
    int   gseen;

    checks   = 0;
    failures = 0;
    cyc_no   = 0;
    reset    = 1'b1;
    req      = 3'b000;

    // Reset state
    add(1, 3'b000, 1, 0, 0, 0, 0);
    // Single request from 0: beep cycles 1-4, done at 5, idle from 7
    add(0, 3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b000, 4, 1, 0, 1, 0);
    add(0, 3'b000, 1, 0, 0, 1, 1);
    add(0, 3'b000, 1, 0, 0, 1, 0);
    add(0, 3'b000, 2, 0, 0, 0, 0);
    // All three at once after reset: 0, 1, 2 back to back at 1, 7, 13
    add(1, 3'b000, 1, 0, 0, 0, 0);
    add(0, 3'b111, 1, 0, 0, 0, 0);
    add(0, 3'b000, 4, 1, 0, 1, 0);
    add(0, 3'b000, 1, 0, 0, 1, 1);
    add(0, 3'b000, 1, 0, 0, 1, 0);
    add(0, 3'b000, 4, 1, 1, 1, 0);
    add(0, 3'b000, 1, 0, 1, 1, 1);
    add(0, 3'b000, 1, 0, 1, 1, 0);
    add(0, 3'b000, 4, 1, 2, 1, 0);
    add(0, 3'b000, 1, 0, 2, 1, 1);
    add(0, 3'b000, 1, 0, 2, 1, 0);
    add(0, 3'b000, 2, 0, 2, 0, 0);
    // Serve 0, re-request {0,2} mid-beep: 2 is served before 0
    add(1, 3'b000, 1, 0, 2, 0, 0);
    add(0, 3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b000, 1, 1, 0, 1, 0);
    add(0, 3'b101, 1, 1, 0, 1, 0);
    add(0, 3'b000, 2, 1, 0, 1, 0);
    add(0, 3'b000, 1, 0, 0, 1, 1);
    add(0, 3'b000, 1, 0, 0, 1, 0);
    add(0, 3'b000, 4, 1, 2, 1, 0);
    add(0, 3'b000, 1, 0, 2, 1, 1);
    add(0, 3'b000, 1, 0, 2, 1, 0);
    add(0, 3'b000, 4, 1, 0, 1, 0);
    add(0, 3'b000, 1, 0, 0, 1, 1);
    add(0, 3'b000, 1, 0, 0, 1, 0);
    add(0, 3'b000, 2, 0, 0, 0, 0);
    // Requester 1 beeps while req[0] pulses three times: one beep for 0
    add(0, 3'b010, 1, 0, 0, 0, 0);
    add(0, 3'b001, 1, 1, 1, 1, 0);
    add(0, 3'b001, 1, 1, 1, 1, 0);
    add(0, 3'b001, 1, 1, 1, 1, 0);
    add(0, 3'b000, 1, 1, 1, 1, 0);
    add(0, 3'b000, 1, 0, 1, 1, 1);
    add(0, 3'b000, 1, 0, 1, 1, 0);
    add(0, 3'b000, 4, 1, 0, 1, 0);
    add(0, 3'b000, 1, 0, 0, 1, 1);
    add(0, 3'b000, 1, 0, 0, 1, 0);
    add(0, 3'b000, 4, 0, 0, 0, 0);
    // Reset in the second beep cycle aborts; pending request for 2 is lost
    add(0, 3'b001, 1, 0, 0, 0, 0);
    add(0, 3'b100, 1, 1, 0, 1, 0);
    add(1, 3'b000, 1, 1, 0, 1, 0);
    add(0, 3'b000, 6, 0, 0, 0, 0);
    // Reset and a request in the same cycle: the request is dropped
    add(1, 3'b010, 1, 0, 0, 0, 0);
    add(0, 3'b000, 5, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        sb_t e;
        @(posedge clk);
        #1;
        reset = (k == 0) ? vecs[i].rst : 1'b0;
        req   = (k == 0) ? vecs[i].req : 3'b000;
        e.row = i;
        e.cyc = cyc_no;
        e.exp = {vecs[i].play, vecs[i].gid, vecs[i].busy, vecs[i].done};
        sb_q.push_back(e);
        cyc_no++;
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 3'b000;
    @(negedge clk);

    // Requester 2 alone after reset: beep length, grant and gap length
    @(posedge clk);
    #1 req = 3'b100;
    @(posedge clk);
    #1 req = 3'b000;
    len      = 0;
    gseen    = -1;
    saw_done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      @(negedge clk);
      if (playNext) begin
        len++;
        gseen = int'(grant_id);
      end
      if (done) saw_done = 1'b1;
    end
    check("done_seen", int'(saw_done), 1);
    check("beep_len", len, 4);
    check("grant_req2", gseen, 2);
    gap     = 1;
    gap_end = 1'b0;
    for (int c = 0; c < 40 && !gap_end; c++) begin
      @(negedge clk);
      if (!busy) gap_end = 1'b1;
      else gap++;
    end
    check("gap_end_seen", int'(gap_end), 1);
    check("gap_len", gap, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 SHALL have parameter BEEP_CYCLES, default 2_500_000, beep length in clk cycles (50 ms at 50 MHz); legal range 1..2^22-1.
REQ-002 SHALL have parameter GAP_CYCLES, default 1_250_000, silent gap after each beep in clk cycles; legal range 1..2^22-1.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, 3, per-requester single-cycle beep request pulses (bit i = requester i).
REQ-006 SHALL have port playNext, output reg, 1, horn drive; high for exactly one beep.
REQ-007 SHALL have port grant_id, output reg, 2, index of the requester being served; valid while playNext is high.
REQ-008 SHALL have port busy, output reg, 1, high in BEEP or GAP.
REQ-009 SHALL have port done, output reg, 1, one-cycle pulse marking beep completion.

Function
REQ-010 SHALL hold a sticky pending bit per requester, set by req[i] and cleared when requester i is granted.
REQ-011 SHALL merge repeated req[i] pulses into one pending beep while pending[i] is already set (no counting).
REQ-012 SHALL set pending[i] again when req[i] arrives during requester i's own BEEP or GAP.
REQ-013 SHALL implement states IDLE, BEEP and GAP; 22-bit counter cleared on every state entry.
REQ-014 IDLE: if (req | pending) is nonzero, SHALL enter BEEP on the next edge, so playNext rises one cycle after a req pulse.
REQ-015 SHALL select the grant round-robin over (req | pending), searching from last_grant+1 upward modulo 3.
REQ-016 After reset, last_grant SHALL be 2, so requester 0 has highest priority.
REQ-017 BEEP SHALL hold playNext=1 for exactly BEEP_CYCLES cycles, then enter GAP.
REQ-018 GAP SHALL hold playNext=0 for exactly GAP_CYCLES cycles.
REQ-019 At the end of GAP, SHALL enter BEEP directly (next round-robin winner) if (req | pending) is nonzero; otherwise enter IDLE.
REQ-020 done SHALL be high only in the first GAP cycle.
REQ-021 grant_id SHALL hold its value from the start of BEEP until the next grant.
REQ-022 busy SHALL equal (state != IDLE).
REQ-023 If reset and req are high in the same cycle, reset SHALL win; the request is dropped.

Reset
REQ-024 Reset SHALL force, on the next edge: state=IDLE, counter=0, pending=0, last_grant=2, playNext=0, grant_id=0, busy=0, done=0.
REQ-025 Reset asserted mid-BEEP or mid-GAP SHALL abort the operation: playNext low on the next edge, no done pulse.

Structure
REQ-026 State encoding, NREQ=3 and the counter width (22) SHALL live in a shared package buzzer_pkg.
REQ-027 SHALL have one sub-module rr_pick3: combinational 3-way round-robin selector with inputs (mask, last_grant) and outputs (valid, index).

Verification (bench: BEEP_CYCLES=4, GAP_CYCLES=2, req pulse in cycle 0)
REQ-028 req=001 -> playNext high cycles 1-4, grant_id=0, done at 5, busy low from 7.
REQ-029 req=111 -> beeps for 0, 1, 2 starting cycles 1, 7, 13, with no IDLE cycle between them.
REQ-030 After serving 0, with pending={0,2} -> requester 2 granted before 0.
REQ-031 req[0] pulsed 3 times while requester 1 beeps -> exactly one beep for requester 0.
REQ-032 reset in cycle 2 of a beep -> playNext=0, busy=0, pending=0 from the next cycle, no done pulse.
REQ-033 reset and req=010 in the same cycle -> no beep follows.
